// File: rtl/si5340_i2c_arbiter.sv
// Round-robin arbiter that runs one 16-bit-address register transaction per grant
// on a shared I2C byte controller; returns done, error code and read data to the requester.
module si5340_i2c_arbiter #(
    parameter int         NUM_REQ     = 3,
    parameter logic [6:0] SLAVE_ADDR  = 7'h74,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     rw_i,
    input  logic [16*NUM_REQ-1:0]  addr_i,
    input  logic [8*NUM_REQ-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [1:0]             err_o,
    output logic [7:0]             rdata_o,
    output logic                   bc_start_o,
    output logic                   bc_stop_o,
    output logic                   bc_read_o,
    output logic                   bc_write_o,
    output logic                   bc_ack_in_o,
    output logic [7:0]             bc_din_o,
    input  logic                   bc_cmd_ack_i,
    input  logic                   bc_ack_out_i,
    input  logic [7:0]             bc_dout_i
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYC);

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_TO   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_SLA, S_AH, S_AL, S_WD, S_RSLA, S_RD, S_ABORT, S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_err;
    logic [1:0]           w_err_next;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_gidx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_rw;
    logic [15:0]          r_addr;
    logic [7:0]           r_wdata;
    logic [CW-1:0]        r_cnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [1:0]           r_err_o;
    logic [7:0]           r_rdata;
    logic                 r_start, r_stop, r_read, r_write, r_ack_in;
    logic [7:0]           r_din;

    logic                 w_start_next, w_stop_next, w_read_next, w_write_next, w_ack_in_next;
    logic [7:0]           w_din_next;
    logic [15:0]          w_addr_arr  [NUM_REQ];
    logic [7:0]           w_wdata_arr [NUM_REQ];
    logic [PW-1:0]        w_pick;
    logic                 w_any_req;
    int                   w_idx;
    logic                 w_in_cmd;
    logic                 w_cmd_live;
    logic                 w_ack;
    logic                 w_timeout;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = addr_i[16*gi +: 16];
            assign w_wdata_arr[gi] = wdata_i[8*gi +: 8];
        end
    endgenerate

    // Scan offsets high to low so the requester closest to the pointer wins.
    always_comb begin
        w_pick    = r_ptr;
        w_any_req = 1'b0;
        w_idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req_i[w_idx]) begin
                w_pick    = PW'(w_idx);
                w_any_req = 1'b1;
            end
        end
    end

    assign w_in_cmd   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_cmd_live = r_start | r_stop | r_read | r_write;
    // An ack only counts while a command is actually on the bus.
    assign w_ack      = w_in_cmd && w_cmd_live && bc_cmd_ack_i;
    assign w_timeout  = w_in_cmd && !w_ack && (r_cnt >= TO_LAST);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_SLA;
                    w_err_next   = ERR_OK;
                end
            end
            S_SLA, S_AH, S_AL, S_RSLA: begin
                if (w_ack) begin
                    if (bc_ack_out_i) begin
                        w_state_next = S_ABORT;
                        w_err_next   = ERR_NACK;
                    end else if (r_state == S_SLA) begin
                        w_state_next = S_AH;
                    end else if (r_state == S_AH) begin
                        w_state_next = S_AL;
                    end else if (r_state == S_AL) begin
                        w_state_next = r_rw ? S_RSLA : S_WD;
                    end else begin
                        w_state_next = S_RD;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                    w_err_next   = ERR_TO;
                end
            end
            S_WD, S_RD: begin
                if (w_ack) begin
                    w_state_next = S_DONE;
                    w_err_next   = (r_state == S_WD && bc_ack_out_i) ? ERR_NACK : ERR_OK;
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                    w_err_next   = ERR_TO;
                end
            end
            S_ABORT: begin
                if (w_ack || w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command bits follow the next state, but are forced low for one cycle after each ack.
    always_comb begin
        w_start_next  = 1'b0;
        w_stop_next   = 1'b0;
        w_read_next   = 1'b0;
        w_write_next  = 1'b0;
        w_ack_in_next = 1'b0;
        w_din_next    = 8'h00;
        if (!(w_ack || w_timeout)) begin
            case (w_state_next)
                S_SLA: begin
                    w_start_next = 1'b1;
                    w_write_next = 1'b1;
                    w_din_next   = {SLAVE_ADDR, 1'b0};
                end
                S_AH: begin
                    w_write_next = 1'b1;
                    w_din_next   = r_addr[15:8];
                end
                S_AL: begin
                    w_write_next = 1'b1;
                    w_din_next   = r_addr[7:0];
                end
                S_WD: begin
                    w_write_next = 1'b1;
                    w_stop_next  = 1'b1;
                    w_din_next   = r_wdata;
                end
                S_RSLA: begin
                    w_start_next = 1'b1;
                    w_write_next = 1'b1;
                    w_din_next   = {SLAVE_ADDR, 1'b1};
                end
                S_RD: begin
                    w_read_next   = 1'b1;
                    w_stop_next   = 1'b1;
                    w_ack_in_next = 1'b1;
                end
                S_ABORT: begin
                    w_stop_next = 1'b1;
                end
                default: begin
                    w_din_next = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_err    <= ERR_OK;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_gnt    <= '0;
            r_rw     <= 1'b0;
            r_addr   <= 16'h0000;
            r_wdata  <= 8'h00;
            r_cnt    <= '0;
            r_done   <= '0;
            r_err_o  <= ERR_OK;
            r_rdata  <= 8'h00;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_ack_in <= 1'b0;
            r_din    <= 8'h00;
        end else begin
            r_err    <= w_err_next;
            r_start  <= w_start_next;
            r_stop   <= w_stop_next;
            r_read   <= w_read_next;
            r_write  <= w_write_next;
            r_ack_in <= w_ack_in_next;
            r_din    <= w_din_next;

            if (!w_in_cmd || w_ack) begin
                r_cnt <= '0;
            end else if (r_cnt != TO_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == S_IDLE && w_any_req) begin
                r_gnt   <= NUM_REQ'(1) << w_pick;
                r_gidx  <= w_pick;
                r_rw    <= rw_i[w_pick];
                r_addr  <= w_addr_arr[w_pick];
                r_wdata <= w_wdata_arr[w_pick];
            end else if (r_state == S_DONE) begin
                r_gnt <= '0;
                r_ptr <= (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
            end

            r_done  <= '0;
            r_err_o <= ERR_OK;
            if (w_state_next == S_DONE && r_state != S_DONE) begin
                r_done  <= r_gnt;
                r_err_o <= w_err_next;
                if (r_state == S_RD && w_ack) begin
                    r_rdata <= bc_dout_i;
                end
            end
        end
    end

    assign gnt_o       = r_gnt;
    assign done_o      = r_done;
    assign err_o       = r_err_o;
    assign rdata_o     = r_rdata;
    assign bc_start_o  = r_start;
    assign bc_stop_o   = r_stop;
    assign bc_read_o   = r_read;
    assign bc_write_o  = r_write;
    assign bc_ack_in_o = r_ack_in;
    assign bc_din_o    = r_din;

endmodule

// File: tb/tb_si5340_i2c_arbiter.sv
// Bench for si5340_i2c_arbiter: byte-controller ack model, a table of single
// transactions, plus timeout, mid-transaction reset and round-robin sequences.
module tb_si5340_i2c_arbiter;

    localparam int NR = 3;
    localparam int TO = 50;

    localparam logic [4:0] F_SW  = 5'b10010;   // {start, stop, read, write, ack_in}
    localparam logic [4:0] F_W   = 5'b00010;
    localparam logic [4:0] F_WP  = 5'b01010;
    localparam logic [4:0] F_RPA = 5'b01101;
    localparam logic [4:0] F_P   = 5'b01000;

    logic            clk_i   = 1'b0;
    logic            arstn_i = 1'b0;
    logic [NR-1:0]   req_i   = '0;
    logic [NR-1:0]   rw_i    = '0;
    logic [16*NR-1:0] addr_i = '0;
    logic [8*NR-1:0] wdata_i = '0;
    logic [NR-1:0]   gnt_o, done_o;
    logic [1:0]      err_o;
    logic [7:0]      rdata_o;
    logic            bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_in_o;
    logic [7:0]      bc_din_o;
    logic            bc_cmd_ack_i = 1'b0;
    logic            bc_ack_out_i = 1'b0;
    logic [7:0]      bc_dout_i    = 8'h00;

    si5340_i2c_arbiter #(
        .NUM_REQ     (NR),
        .SLAVE_ADDR  (7'h74),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .req_i        (req_i),
        .rw_i         (rw_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .bc_start_o   (bc_start_o),
        .bc_stop_o    (bc_stop_o),
        .bc_read_o    (bc_read_o),
        .bc_write_o   (bc_write_o),
        .bc_ack_in_o  (bc_ack_in_o),
        .bc_din_o     (bc_din_o),
        .bc_cmd_ack_i (bc_cmd_ack_i),
        .bc_ack_out_i (bc_ack_out_i),
        .bc_dout_i    (bc_dout_i)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Byte-controller model: acks each command after ack_delay cycles, logs every command issued.
    int          ack_delay  = 10;
    bit          ack_en     = 1'b1;
    int          nack_at    = -1;
    logic [7:0]  slave_byte = 8'h00;
    int          acks_total = 0;
    int          ack_cnt    = 0;
    int          cyc        = 0;
    int          onehot_err = 0;
    logic        prev_live  = 1'b0;
    logic [12:0] log_q [$];
    wire         w_live = bc_start_o | bc_stop_o | bc_read_o | bc_write_o;

    always @(negedge clk_i) begin
        if (w_live && !prev_live) begin
            log_q.push_back({bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_in_o, bc_din_o});
        end
        prev_live    = w_live;
        bc_cmd_ack_i = 1'b0;
        bc_ack_out_i = 1'b0;
        if (w_live && ack_en) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
                bc_cmd_ack_i = 1'b1;
                bc_ack_out_i = (acks_total == nack_at);
                bc_dout_i    = slave_byte;
                ack_cnt      = 0;
                acks_total++;
            end
        end else begin
            ack_cnt = 0;
        end
        if (!$onehot0(gnt_o)) onehot_err++;
        cyc++;
    end

    typedef struct packed {
        logic [1:0]       rq;
        logic             rw;
        logic [15:0]      addr;
        logic [7:0]       wdata;
        logic [7:0]       sbyte;
        logic [3:0]       nack_k;    // command index to NACK, 4'hF = none
        logic [1:0]       err;
        logic [7:0]       rdata;
        logic [2:0]       n;
        logic [4:0][12:0] cmd;
    } vec_t;

    vec_t tbl [7];
    logic [NR-1:0] rr_exp [4];

    function automatic vec_t mkv(input logic [1:0] rq, input logic rw, input logic [15:0] addr,
                                 input logic [7:0] wd, input logic [7:0] sb, input logic [3:0] nk,
                                 input logic [1:0] err, input logic [7:0] rd, input logic [2:0] n,
                                 input logic [12:0] c0, input logic [12:0] c1, input logic [12:0] c2,
                                 input logic [12:0] c3, input logic [12:0] c4);
        vec_t v;
        v.rq = rq; v.rw = rw; v.addr = addr; v.wdata = wd; v.sbyte = sb;
        v.nack_k = nk; v.err = err; v.rdata = rd; v.n = n;
        v.cmd[0] = c0; v.cmd[1] = c1; v.cmd[2] = c2; v.cmd[3] = c3; v.cmd[4] = c4;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, output logic [NR-1:0] d, output logic [NR-1:0] g,
                             output logic [1:0] e, output logic [7:0] r, output int at,
                             output logic [4:0] cb);
        bit seen;
        seen = 1'b0; d = '0; g = '0; e = '0; r = '0; at = -1; cb = '1;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk_i); #1;
            if (|done_o) begin
                seen = 1'b1;
                d = done_o; g = gnt_o; e = err_o; r = rdata_o; at = cyc;
                cb = {bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_in_o};
            end
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int base, at;
        logic [NR-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        logic [4:0] cb;
        logic [12:0] act;
        v = tbl[i];
        base = log_q.size();
        nack_at = (v.nack_k == 4'hF) ? -1 : acks_total + int'(v.nack_k);
        slave_byte = v.sbyte;
        rw_i[v.rq] = v.rw;
        addr_i[16*v.rq +: 16] = v.addr;
        wdata_i[8*v.rq +: 8] = v.wdata;
        req_i = NR'(1) << v.rq;
        wait_done(400, d, g, e, r, at, cb);
        req_i = '0;
        chk($sformatf("v%0d done_o", i), 32'(d), 32'(NR'(1) << v.rq));
        chk($sformatf("v%0d gnt_o at done", i), 32'(g), 32'(NR'(1) << v.rq));
        chk($sformatf("v%0d err_o", i), 32'(e), 32'(v.err));
        chk($sformatf("v%0d rdata_o", i), 32'(r), 32'(v.rdata));
        @(negedge clk_i); #1;
        chk($sformatf("v%0d gnt_o after done", i), 32'(gnt_o), 32'd0);
        chk($sformatf("v%0d command count", i), 32'(log_q.size() - base), 32'(v.n));
        for (int k = 0; k < int'(v.n); k++) begin
            act = (base + k < log_q.size()) ? log_q[base + k] : 13'h1FFF;
            chk($sformatf("v%0d cmd%0d {flags,din}", i, k), 32'(act), 32'(v.cmd[k]));
        end
        $display("vec %0d: req%0d rw=%0d addr=%04h err=%0d rdata=%02h cmds=%0d",
                 i, v.rq, v.rw, v.addr, e, r, log_q.size() - base);
    endtask

    initial begin
        int base, t0, at;
        logic [NR-1:0] d, g;
        logic [1:0] e;
        logic [7:0] r;
        logic [4:0] cb;

        tbl[0] = mkv(2'd0, 1'b0, 16'h0B24, 8'hC0, 8'h00, 4'hF, 2'd0, 8'h00, 3'd4,
                     {F_SW, 8'hE8}, {F_W, 8'h0B}, {F_W, 8'h24}, {F_WP, 8'hC0}, 13'h0);
        tbl[1] = mkv(2'd1, 1'b1, 16'h00FE, 8'h00, 8'h0F, 4'hF, 2'd0, 8'h0F, 3'd5,
                     {F_SW, 8'hE8}, {F_W, 8'h00}, {F_W, 8'hFE}, {F_SW, 8'hE9}, {F_RPA, 8'h00});
        tbl[2] = mkv(2'd2, 1'b0, 16'h1234, 8'h55, 8'h00, 4'd1, 2'd1, 8'h0F, 3'd3,
                     {F_SW, 8'hE8}, {F_W, 8'h12}, {F_P, 8'h00}, 13'h0, 13'h0);
        tbl[3] = mkv(2'd0, 1'b0, 16'h0A0B, 8'h77, 8'h00, 4'd3, 2'd1, 8'h0F, 3'd4,
                     {F_SW, 8'hE8}, {F_W, 8'h0A}, {F_W, 8'h0B}, {F_WP, 8'h77}, 13'h0);
        tbl[4] = mkv(2'd1, 1'b1, 16'h5A5A, 8'h00, 8'h3C, 4'd3, 2'd1, 8'h0F, 3'd5,
                     {F_SW, 8'hE8}, {F_W, 8'h5A}, {F_W, 8'h5A}, {F_SW, 8'hE9}, {F_P, 8'h00});
        tbl[5] = mkv(2'd2, 1'b1, 16'h8001, 8'h00, 8'hA5, 4'hF, 2'd0, 8'hA5, 3'd5,
                     {F_SW, 8'hE8}, {F_W, 8'h80}, {F_W, 8'h01}, {F_SW, 8'hE9}, {F_RPA, 8'h00});
        tbl[6] = mkv(2'd0, 1'b0, 16'h00FF, 8'h12, 8'h00, 4'd0, 2'd1, 8'hA5, 3'd2,
                     {F_SW, 8'hE8}, {F_P, 8'h00}, 13'h0, 13'h0, 13'h0);
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        chk("reset gnt_o", 32'(gnt_o), 32'd0);
        chk("reset done_o", 32'(done_o), 32'd0);
        chk("reset err_o/rdata_o", 32'({err_o, rdata_o}), 32'd0);
        chk("reset bc cmd/din", 32'({bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_in_o, bc_din_o}), 32'd0);
        arstn_i = 1'b1;
        @(negedge clk_i); #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // Timeout: no acks at all
        ack_en = 1'b0;
        base = log_q.size();
        rw_i[0] = 1'b0; addr_i[15:0] = 16'h0001; wdata_i[7:0] = 8'h00;
        req_i = 3'b001;
        t0 = -1000;
        for (int k = 0; k < 20 && log_q.size() <= base; k++) begin
            @(negedge clk_i); #1;
        end
        t0 = cyc;
        wait_done(200, d, g, e, r, at, cb);
        req_i = '0;
        chk("timeout done_o", 32'(d), 32'b001);
        chk("timeout err_o", 32'(e), 32'd2);
        chk("timeout rdata_o kept", 32'(r), 32'hA5);
        chk("timeout cycles after SLA", 32'(at - t0), 32'(TO));
        chk("timeout cmd bits at done", 32'(cb), 32'd0);
        @(negedge clk_i); #1;
        chk("timeout no stop issued", 32'(log_q.size() - base), 32'd1);
        ack_en = 1'b1;
        $display("timeout: err=%0d latency=%0d", e, at - t0);

        // Asynchronous reset during AL, then req2 pending
        base = log_q.size();
        nack_at = -1;
        rw_i[0] = 1'b0; addr_i[15:0] = 16'h0B24; wdata_i[7:0] = 8'hC0;
        req_i = 3'b001;
        for (int k = 0; k < 100 && log_q.size() < base + 3; k++) begin
            @(negedge clk_i); #1;
        end
        chk("reset-test reached AL", 32'(log_q.size() - base), 32'd3);
        #2;
        arstn_i = 1'b0;
        #1;
        chk("async reset gnt_o", 32'(gnt_o), 32'd0);
        chk("async reset done/err", 32'({done_o, err_o}), 32'd0);
        chk("async reset rdata_o", 32'(rdata_o), 32'd0);
        chk("async reset bc cmd/din", 32'({bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_in_o, bc_din_o}), 32'd0);
        req_i = 3'b100;
        rw_i[2] = 1'b0; addr_i[47:32] = 16'h0102; wdata_i[23:16] = 8'h33;
        repeat (2) @(negedge clk_i);
        #1;
        arstn_i = 1'b1;
        base = log_q.size();
        for (int k = 0; k < 10 && gnt_o == '0; k++) begin
            @(negedge clk_i); #1;
        end
        chk("post-reset grant", 32'(gnt_o), 32'b100);
        wait_done(200, d, g, e, r, at, cb);
        req_i = '0;
        chk("post-reset done_o", 32'(d), 32'b100);
        chk("post-reset err_o", 32'(e), 32'd0);
        chk("post-reset first cmd", 32'((log_q.size() > base) ? log_q[base] : 13'h1FFF), 32'({F_SW, 8'hE8}));
        @(negedge clk_i); #1;
        $display("reset-mid-AL: regrant=req2 err=%0d", e);

        // Round robin with all requesters held high
        rw_i = '0;
        onehot_err = 0;
        req_i = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_done(200, d, g, e, r, at, cb);
            if (k == 3) req_i = '0;
            chk($sformatf("rr%0d done_o", k), 32'(d), 32'(rr_exp[k]));
            chk($sformatf("rr%0d gnt_o", k), 32'(g), 32'(rr_exp[k]));
            chk($sformatf("rr%0d err_o", k), 32'(e), 32'd0);
            @(negedge clk_i); #1;
            chk($sformatf("rr%0d idle gap", k), 32'(gnt_o), 32'd0);
            $display("rr %0d: done=%03b err=%0d", k, d, e);
        end
        chk("grant one-hot violations", 32'(onehot_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
